// File: rtl/sand_pkg.sv
// rtl/sand_pkg.sv - shared types and constants for the sand engine blocks
// Purpose: particle encoding, HPS kernel register map, brush command record,
//          playfield geometry and the pixel-merge helper.
// Ports:   none (package).
package sand_pkg;

  typedef enum logic [1:0] {
    P_EMPTY = 2'd0,
    P_SAND  = 2'd1,
    P_WALL  = 2'd2,
    P_WATER = 2'd3
  } particle_t;

  localparam logic [2:0] KADDR_X      = 3'd0;
  localparam logic [2:0] KADDR_Y      = 3'd1;
  localparam logic [2:0] KADDR_COMMIT = 3'd2;

  localparam int ROW_WORDS   = 80;
  localparam int PX_PER_WORD = 8;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    particle_t   ptype;
  } brush_cmd_t;

  // Replace the 2-bit field of pixel px (px 0 lives in bits [15:14]) with ptype.
  function automatic logic [15:0] merge_pixel(input logic [15:0] word,
                                              input logic [2:0]  px,
                                              input particle_t   ptype);
    logic [3:0] sh;
    sh = {~px, 1'b0};  // 2*(7-px) == 14-2*px
    merge_pixel = (word & ~(16'h0003 << sh)) | ({14'd0, ptype} << sh);
  endfunction

endpackage

// File: rtl/sand_cmd_fifo.sv
// rtl/sand_cmd_fifo.sv - synchronous FIFO of brush commands
// Purpose: small command queue between the HPS kernel port and the RMW engine.
// Ports:   clock, reset (async active-low)
//          push, push_data : enqueue request and record
//          pop, pop_data   : dequeue request, head record (valid when !empty)
//          full, empty     : occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
module sand_cmd_fifo
  import sand_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  brush_cmd_t push_data,
  input  logic       pop,
  output brush_cmd_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  brush_cmd_t       slots [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = slots[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) slots[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sand_brush.sv
// rtl/sand_brush.sv - HPS brush commands to SDRAM read-modify-write of the playfield
// Purpose: stages x/y from the kernel port, queues commits, and performs one
//          RMW per command while the arbiter grants the SDRAM port.
// Ports:   clock, reset (async active-low)
//          kernel_chipselect/write/address/writedata : HPS register writes
//          mem_req/mem_grant                         : arbiter handshake
//          mem_address/read/write/writedata          : SDRAM master strobes
//          mem_waitrequest/readdatavalid/readdata    : SDRAM slave responses
//          busy       : queue non-empty or engine active
//          drop_count : saturating count of rejected commits
module sand_brush
  import sand_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int          SCREEN_W   = 640,
  parameter int          SCREEN_H   = 480,
  parameter int          ROW_WORDS  = sand_pkg::ROW_WORDS,
  parameter logic [23:0] BASE_ADDR  = 24'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        kernel_chipselect,
  input  logic        kernel_write,
  input  logic [2:0]  kernel_address,
  input  logic [15:0] kernel_writedata,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [23:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [15:0] mem_readdata,
  output logic [15:0] mem_writedata,
  output logic        busy,
  output logic [7:0]  drop_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_RWAIT,
    S_WR,
    S_REL
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [10:0] stage_x;
  logic [9:0]  stage_y;
  logic [2:0]  work_px;
  particle_t   work_type;
  logic [23:0] addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  drop_q;

  brush_cmd_t  fifo_head;
  brush_cmd_t  push_cmd;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        kernel_wr;
  logic        commit;
  logic        in_range;
  logic        accept;
  logic [23:0] addr_calc;
  logic        unused_ok;

  assign unused_ok = &{1'b0, kernel_writedata[15:11]};

  assign kernel_wr = kernel_chipselect && kernel_write;
  assign commit    = kernel_wr && (kernel_address == KADDR_COMMIT);
  assign in_range  = (stage_x < 11'(SCREEN_W)) && (stage_y < 10'(SCREEN_H));
  // A full queue still takes the commit if the engine pops in the same cycle.
  assign accept    = commit && in_range && (!fifo_full || pop);

  assign push_cmd = '{x: stage_x, y: stage_y, ptype: particle_t'(kernel_writedata[1:0])};

  assign addr_calc = BASE_ADDR + 24'(fifo_head.y) * 24'(ROW_WORDS) + 24'(fifo_head.x[10:3]);

  sand_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (accept),
    .push_data(push_cmd),
    .pop      (pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      stage_x   <= '0;
      stage_y   <= '0;
      work_px   <= '0;
      work_type <= P_EMPTY;
      addr_q    <= '0;
      wdata_q   <= '0;
      drop_q    <= '0;
    end else begin
      state <= state_nx;
      if (kernel_wr && kernel_address == KADDR_X) stage_x <= kernel_writedata[10:0];
      if (kernel_wr && kernel_address == KADDR_Y) stage_y <= kernel_writedata[9:0];
      if (pop) begin
        work_px   <= fifo_head.x[2:0];
        work_type <= fifo_head.ptype;
        addr_q    <= addr_calc;
      end
      if (state == S_RWAIT && mem_grant && mem_readdatavalid)
        wdata_q <= merge_pixel(mem_readdata, work_px, work_type);
      if (commit && !accept && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  // Strobes decode straight from the state register so a reset drops them
  // immediately and acceptance clears them on the following cycle.
  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    mem_req   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_grant) state_nx = S_RD;
      end
      S_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (!mem_grant)           state_nx = S_REQ;
        else if (!mem_waitrequest) state_nx = S_RWAIT;
      end
      S_RWAIT: begin
        mem_req = 1'b1;
        if (!mem_grant)             state_nx = S_REQ;
        else if (mem_readdatavalid) state_nx = S_WR;
      end
      S_WR: begin
        // The write is completed even if grant drops, so the word is never torn.
        mem_req   = 1'b1;
        mem_write = 1'b1;
        if (!mem_waitrequest) state_nx = S_REL;
      end
      S_REL: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign drop_count    = drop_q;
  assign busy          = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_sand_brush.sv
// tb/tb_sand_brush.sv - self-checking bench for sand_brush
module tb_sand_brush;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        kernel_chipselect = 1'b0;
  logic        kernel_write = 1'b0;
  logic [2:0]  kernel_address = 3'd0;
  logic [15:0] kernel_writedata = 16'd0;
  logic        mem_req;
  logic        mem_grant;
  logic [23:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic        mem_waitrequest = 1'b0;
  logic        mem_readdatavalid = 1'b0;
  logic [15:0] mem_readdata = 16'd0;
  logic [15:0] mem_writedata;
  logic        busy;
  logic [7:0]  drop_count;

  sand_brush dut (
    .clock            (clock),
    .reset            (reset),
    .kernel_chipselect(kernel_chipselect),
    .kernel_write     (kernel_write),
    .kernel_address   (kernel_address),
    .kernel_writedata (kernel_writedata),
    .mem_req          (mem_req),
    .mem_grant        (mem_grant),
    .mem_address      (mem_address),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_waitrequest  (mem_waitrequest),
    .mem_readdatavalid(mem_readdatavalid),
    .mem_readdata     (mem_readdata),
    .mem_writedata    (mem_writedata),
    .busy             (busy),
    .drop_count       (drop_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int x;
    int y;
    int t;
  } cmd_t;

  cmd_t       exp_q[$];
  bit [15:0]  smem[int];
  int         model_drops = 0;
  int         n_pushed = 0;

  function automatic bit [15:0] word_at(input int a);
    if (smem.exists(a)) return smem[a];
    return 16'(a * 37 + 11);
  endfunction

  function automatic int exp_addr(input cmd_t c);
    return c.y * 80 + c.x / 8;
  endfunction

  function automatic bit [15:0] exp_word(input bit [15:0] w, input cmd_t c);
    int sh;
    int oldpx;
    sh    = 2 * (7 - c.x % 8);
    oldpx = int'((w >> sh) & 16'd3);
    return 16'(int'(w) - (oldpx << sh) + (c.t << sh));
  endfunction

  // ---------------- SDRAM slave ----------------
  bit          grant = 1'b1;
  assign mem_grant = grant;

  int          stall_rd = 0;
  int          stall_wr = 0;
  int          rd_lat = 0;
  int          n_reads = 0;
  int          n_writes = 0;
  int          rd_hi = 0;
  int          wr_hi = 0;
  bit          in_xfer = 1'b0;
  int          stalled = 0;
  logic [23:0] cap_addr;
  logic [15:0] cap_wdata;
  logic        cap_rd;
  bit          rd_pending = 1'b0;
  int          rd_delay = 0;
  bit [15:0]   rd_word;
  int          last_rdv_cyc = 0;
  int          last_wr_start_cyc = 0;
  logic [23:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;

  always @(negedge clock) begin
    cmd_t c;
    mem_readdatavalid = 1'b0;
    if (rd_pending) begin
      if (rd_delay == 0) begin
        mem_readdatavalid = 1'b1;
        mem_readdata      = rd_word;
        rd_pending        = 1'b0;
        last_rdv_cyc      = cyc;
      end else begin
        rd_delay--;
      end
    end
    mem_waitrequest = 1'b0;
    if (mem_read || mem_write) check("strobe_excl", 32'(mem_read & mem_write), 32'd0);
    if (grant && reset && (mem_read || mem_write)) begin
      if (mem_read) rd_hi++;
      else wr_hi++;
      if (!in_xfer) begin
        in_xfer   = 1'b1;
        stalled   = 0;
        cap_addr  = mem_address;
        cap_wdata = mem_writedata;
        cap_rd    = mem_read;
        if (mem_write) last_wr_start_cyc = cyc;
      end else begin
        check("hold_addr", 32'(mem_address), 32'(cap_addr));
        check("hold_kind", 32'(mem_read), 32'(cap_rd));
        if (mem_write) check("hold_wdata", 32'(mem_writedata), 32'(cap_wdata));
      end
      if (stalled < (mem_read ? stall_rd : stall_wr)) begin
        mem_waitrequest = 1'b1;
        stalled++;
      end else begin
        in_xfer = 1'b0;
        check("access_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          if (mem_read) begin
            n_reads++;
            check("rd_addr", 32'(mem_address), 32'(exp_addr(exp_q[0])));
            rd_pending = 1'b1;
            rd_delay   = rd_lat;
            rd_word    = word_at(int'(mem_address));
          end else begin
            n_writes++;
            c = exp_q.pop_front();
            check("wr_addr", 32'(mem_address), 32'(exp_addr(c)));
            check("wr_data", 32'(mem_writedata), 32'(exp_word(word_at(exp_addr(c)), c)));
            smem[int'(mem_address)] = mem_writedata;
            last_wr_addr = mem_address;
            last_wr_data = mem_writedata;
          end
        end
      end
    end else begin
      in_xfer = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic kwrite(input logic [2:0] a, input logic [15:0] d);
    kernel_chipselect = 1'b1;
    kernel_write      = 1'b1;
    kernel_address    = a;
    kernel_writedata  = d;
    @(negedge clock);
    kernel_chipselect = 1'b0;
    kernel_write      = 1'b0;
    kernel_writedata  = 16'($urandom);
  endtask

  task automatic commit(input int x, input int y, input int t, input bit room);
    cmd_t c;
    c.x = x;
    c.y = y;
    c.t = t;
    kwrite(3'd0, {5'($urandom), 11'(x)});
    kwrite(3'd1, {6'($urandom), 10'(y)});
    if (x < 640 && y < 480 && room) begin
      exp_q.push_back(c);
      n_pushed++;
    end else if (model_drops < 255) begin
      model_drops++;
    end
    kwrite(3'd2, {14'($urandom), 2'(t)});
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() > 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    int        x;
    int        y;
    int        t;
    bit [15:0] pre;
    int        eaddr;
    bit [15:0] edata;
    bit        drop;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int r0;
    int w0;
    int d0;
    int n;
    int rh0;
    int wh0;

    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int w0;
    int d0;
    int n;
    int rh0;
    int wh0;
    int p0;

    tbl[0] = '{13, 2, 2, 16'h0000, 161, 16'h0020, 1'b0};
    tbl[1] = '{639, 479, 1, 16'hFFFF, 38399, 16'hFFFD, 1'b0};
    tbl[2] = '{640, 0, 1, 16'h0000, 0, 16'h0000, 1'b1};
    tbl[3] = '{0, 480, 3, 16'h0000, 0, 16'h0000, 1'b1};
    tbl[4] = '{0, 0, 3, 16'h1234, 0, 16'hD234, 1'b0};
    tbl[5] = '{7, 1, 0, 16'hFFFF, 80, 16'hFFFC, 1'b0};
    tbl[6] = '{100, 10, 1, 16'hAAAA, 812, 16'hAA6A, 1'b0};

    // reset state
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_writedata", 32'(mem_writedata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // directed vectors, grant held, zero wait
    for (int i = 0; i < 7; i++) begin
      if (!tbl[i].drop) smem[tbl[i].eaddr] = tbl[i].pre;
      r0 = n_reads;
      w0 = n_writes;
      d0 = int'(drop_count);
      commit(tbl[i].x, tbl[i].y, tbl[i].t, 1'b1);
      if (i == 0) begin
        check("lat_cycle1_read", 32'(mem_read), 32'd0);
        @(negedge clock);
        check("lat_cycle2_read", 32'(mem_read), 32'd0);
        @(negedge clock);
        check("lat_cycle3_read", 32'(mem_read), 32'd1);
      end
      wait_idle(100, "tbl");
      repeat (3) @(negedge clock);
      check("tbl_reads", 32'(n_reads - r0), 32'(!tbl[i].drop));
      check("tbl_writes", 32'(n_writes - w0), 32'(!tbl[i].drop));
      check("tbl_drop_count", 32'(drop_count), 32'(d0 + int'(tbl[i].drop)));
      if (!tbl[i].drop) begin
        check("tbl_wr_addr", 32'(last_wr_addr), 32'(tbl[i].eaddr));
        check("tbl_wr_data", 32'(last_wr_data), 32'(tbl[i].edata));
        check("tbl_wr_after_rdv",
              32'((last_wr_start_cyc - last_rdv_cyc >= 1) && (last_wr_start_cyc - last_rdv_cyc <= 2)),
              32'd1);
      end
    end

    // waitrequest held 5 cycles on both read and write
    stall_rd = 5;
    stall_wr = 5;
    r0  = n_reads;
    w0  = n_writes;
    rh0 = rd_hi;
    wh0 = wr_hi;
    commit(200, 100, 3, 1'b1);
    wait_idle(200, "stall");
    check("stall_reads", 32'(n_reads - r0), 32'd1);
    check("stall_writes", 32'(n_writes - w0), 32'd1);
    check("stall_read_hold_cycles", 32'(rd_hi - rh0), 32'd6);
    check("stall_write_hold_cycles", 32'(wr_hi - wh0), 32'd6);
    stall_rd = 0;
    stall_wr = 0;

    // grant removed while waiting for read data; late data must be ignored
    rd_lat = 2;
    r0 = n_reads;
    w0 = n_writes;
    commit(321, 77, 2, 1'b1);
    n = 0;
    while (n_reads == r0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("retry_first_read_seen", 32'(n_reads - r0), 32'd1);
    @(negedge clock);
    grant = 1'b0;
    @(negedge clock);
    check("retry_req_held", 32'(mem_req), 32'd1);
    repeat (2) @(negedge clock);
    grant = 1'b1;
    wait_idle(100, "retry");
    check("retry_reads", 32'(n_reads - r0), 32'd2);
    check("retry_writes", 32'(n_writes - w0), 32'd1);
    rd_lat = 0;

    // overflow with no grant: one command in service, eight queued, ninth dropped
    grant = 1'b0;
    r0 = n_reads;
    w0 = n_writes;
    d0 = int'(drop_count);
    commit(33, 40, 1, 1'b1);
    repeat (3) @(negedge clock);
    for (int k = 0; k < 9; k++)
      commit((k < 2) ? 5 : 8 * k + 3, 20, k % 4, k < 8);
    repeat (2) @(negedge clock);
    check("ovf_drop_count", 32'(drop_count), 32'(d0 + 1));
    check("ovf_busy", 32'(busy), 32'd1);
    check("ovf_no_access", 32'(n_reads - r0), 32'd0);
    grant = 1'b1;
    wait_idle(600, "ovf");
    check("ovf_writes", 32'(n_writes - w0), 32'd9);

    // randomized commands with random slave timing
    w0 = n_writes;
    p0 = n_pushed;
    for (int g = 0; g < 10; g++) begin
      stall_rd = $urandom_range(0, 3);
      stall_wr = $urandom_range(0, 3);
      rd_lat   = $urandom_range(0, 2);
      for (int j = 0; j < 4; j++)
        commit($urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 3), 1'b1);
      wait_idle(600, "rand");
    end
    check("rand_writes", 32'(n_writes - w0), 32'(n_pushed - p0));
    check("rand_drop_count", 32'(drop_count), 32'(model_drops));
    stall_rd = 0;
    stall_wr = 0;
    rd_lat   = 0;

    // drop counter saturation
    for (int k = 0; k < 260; k++) commit(700, 0, 1, 1'b1);
    check("sat_drop_count", 32'(drop_count), 32'd255);

    // reset during a stalled write: everything clears at once, queue lost
    stall_wr = 20;
    commit(50, 60, 1, 1'b1);
    commit(51, 60, 2, 1'b1);
    n = 0;
    while (!mem_write && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("rstwr_write_reached", 32'(mem_write), 32'd1);
    r0 = n_reads;
    w0 = n_writes;
    reset = 1'b0;
    #1;
    check("rstwr_mem_write", 32'(mem_write), 32'd0);
    check("rstwr_mem_read", 32'(mem_read), 32'd0);
    check("rstwr_mem_req", 32'(mem_req), 32'd0);
    check("rstwr_busy", 32'(busy), 32'd0);
    check("rstwr_mem_address", 32'(mem_address), 32'd0);
    check("rstwr_mem_writedata", 32'(mem_writedata), 32'd0);
    check("rstwr_drop_count", 32'(drop_count), 32'd0);
    exp_q.delete();
    model_drops = 0;
    @(negedge clock);
    reset = 1'b1;
    stall_wr = 0;
    repeat (10) @(negedge clock);
    check("rstwr_queue_lost", 32'(busy), 32'd0);
    check("rstwr_no_reads", 32'(n_reads - r0), 32'd0);
    check("rstwr_no_writes", 32'(n_writes - w0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
